// File: rtl/dispatcher_pkg.sv
// Shared defaults and derived widths for the dispatcher and its per-output queues.
package dispatcher_pkg;

   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned N_DEF     = 4;
   localparam int unsigned DEPTH_DEF = 2;

   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   localparam int unsigned DEST_W = clog2_min1(N_DEF);
   localparam int unsigned PTR_W  = clog2_min1(DEPTH_DEF);
   localparam int unsigned CNT_W  = $clog2(DEPTH_DEF + 1);

endpackage

// File: rtl/dispatcher_queue.sv
// Single DEPTH-entry FIFO with a registered occupancy count; no empty bypass.
module dispatcher_queue
   import dispatcher_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned PW    = clog2_min1(DEPTH),
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enq,
   input  logic [WIDTH-1:0] enq_bits,
   input  logic             deq_ready,
   output logic             valid,
   output logic [WIDTH-1:0] bits,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             deq;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Valid is masked during reset so no consumer sees a fire in the reset cycle.
   assign valid = reset & (count_q != '0);
   assign bits  = mem[rd_ptr_q];
   assign count = count_q;
   assign deq   = valid & deq_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) wr_ptr_d = ptr_next(wr_ptr_q);
      if (deq) rd_ptr_d = ptr_next(rd_ptr_q);
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr_q] <= enq_bits;
   end

endmodule

// File: rtl/dispatcher.sv
// Routes input beats to one of N per-destination queues by io_in_dest.
// The named output port list is elaborated for N = 4.
module dispatcher
   import dispatcher_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned N      = N_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned DW     = clog2_min1(N),
   parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_in_bits,
   input  logic [DW-1:0]    io_in_dest,
   output logic             io_out_0_valid,
   input  logic             io_out_0_ready,
   output logic [WIDTH-1:0] io_out_0_bits,
   output logic             io_out_1_valid,
   input  logic             io_out_1_ready,
   output logic [WIDTH-1:0] io_out_1_bits,
   output logic             io_out_2_valid,
   input  logic             io_out_2_ready,
   output logic [WIDTH-1:0] io_out_2_bits,
   output logic             io_out_3_valid,
   input  logic             io_out_3_ready,
   output logic [WIDTH-1:0] io_out_3_bits,
   output logic             io_fire
);

   logic [N-1:0]     enq;
   logic [N-1:0]     q_valid;
   logic [N-1:0]     q_ready;
   logic [WIDTH-1:0] q_bits  [N];
   logic [CW-1:0]    q_count [N];

   assign q_ready = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};

   assign io_out_0_valid = q_valid[0];
   assign io_out_1_valid = q_valid[1];
   assign io_out_2_valid = q_valid[2];
   assign io_out_3_valid = q_valid[3];
   assign io_out_0_bits  = q_bits[0];
   assign io_out_1_bits  = q_bits[1];
   assign io_out_2_bits  = q_bits[2];
   assign io_out_3_bits  = q_bits[3];

   // Registered count only: a same-cycle dequeue never frees space for this beat.
   assign io_in_ready = reset & (q_count[io_in_dest] < CW'(DEPTH));
   assign io_fire     = io_in_valid & io_in_ready;

   always_comb begin
      enq             = '0;
      enq[io_in_dest] = io_fire;
   end

   for (genvar i = 0; i < N; i++) begin : g_queue
      dispatcher_queue #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_queue (
         .clk       (clk),
         .reset     (reset),
         .enq       (enq[i]),
         .enq_bits  (io_in_bits),
         .deq_ready (q_ready[i]),
         .valid     (q_valid[i]),
         .bits      (q_bits[i]),
         .count     (q_count[i])
      );
   end

endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for dispatcher: routing, full queues, no pass-through, wrap and reset.
module tb_dispatcher;

   logic       clk = 1'b0;
   logic       reset;
   logic       io_in_valid;
   logic       io_in_ready;
   logic [7:0] io_in_bits;
   logic [1:0] io_in_dest;
   logic       io_out_0_valid, io_out_1_valid, io_out_2_valid, io_out_3_valid;
   logic       io_out_0_ready, io_out_1_ready, io_out_2_ready, io_out_3_ready;
   logic [7:0] io_out_0_bits, io_out_1_bits, io_out_2_bits, io_out_3_bits;
   logic       io_fire;

   int total = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dispatcher dut (
      .clk            (clk),
      .reset          (reset),
      .io_in_valid    (io_in_valid),
      .io_in_ready    (io_in_ready),
      .io_in_bits     (io_in_bits),
      .io_in_dest     (io_in_dest),
      .io_out_0_valid (io_out_0_valid),
      .io_out_0_ready (io_out_0_ready),
      .io_out_0_bits  (io_out_0_bits),
      .io_out_1_valid (io_out_1_valid),
      .io_out_1_ready (io_out_1_ready),
      .io_out_1_bits  (io_out_1_bits),
      .io_out_2_valid (io_out_2_valid),
      .io_out_2_ready (io_out_2_ready),
      .io_out_2_bits  (io_out_2_bits),
      .io_out_3_valid (io_out_3_valid),
      .io_out_3_ready (io_out_3_ready),
      .io_out_3_bits  (io_out_3_bits),
      .io_fire        (io_fire)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then move two time units away from it before touching anything.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic offer(input logic v, input logic [1:0] d, input logic [7:0] b);
      io_in_valid = v;
      io_in_dest  = d;
      io_in_bits  = b;
      #1;
   endtask

   task automatic chk_valids(input string tag, input logic [3:0] exp);
      chk(tag, {io_out_3_valid, io_out_2_valid, io_out_1_valid, io_out_0_valid}, exp);
   endtask

   initial begin
      reset          = 1'b0;
      io_in_valid    = 1'b0;
      io_in_bits     = '0;
      io_in_dest     = '0;
      io_out_0_ready = 1'b0;
      io_out_1_ready = 1'b0;
      io_out_2_ready = 1'b0;
      io_out_3_ready = 1'b0;
      step();
      step();

      // During reset a beat is refused.
      offer(1'b1, 2'd0, 8'hAA);
      chk("rst_in_ready", io_in_ready, 1'b0);
      chk("rst_fire", io_fire, 1'b0);
      step();
      reset = 1'b1;
      offer(1'b0, 2'd0, 8'h00);
      chk_valids("post_rst_valids", 4'b0000);
      chk("post_rst_fire", io_fire, 1'b0);

      // Basic route.
      offer(1'b1, 2'd2, 8'h5A);
      chk("route_ready", io_in_ready, 1'b1);
      chk("route_fire", io_fire, 1'b1);
      step();
      offer(1'b0, 2'd0, 8'h00);
      chk_valids("route_valids", 4'b0100);
      chk("route_bits", io_out_2_bits, 8'h5A);
      io_out_2_ready = 1'b1;
      step();
      io_out_2_ready = 1'b0;
      #1;
      chk_valids("route_drained", 4'b0000);

      // Fill queue 1.
      offer(1'b1, 2'd1, 8'h11);
      step();
      offer(1'b1, 2'd1, 8'h22);
      chk("fill2_ready", io_in_ready, 1'b1);
      step();
      offer(1'b1, 2'd1, 8'h33);
      chk("full_ready", io_in_ready, 1'b0);
      chk("full_fire", io_fire, 1'b0);
      offer(1'b1, 2'd3, 8'hC3);
      chk("other_ready", io_in_ready, 1'b1);
      chk("other_fire", io_fire, 1'b1);
      step();
      offer(1'b0, 2'd0, 8'h00);
      chk_valids("full_valids", 4'b1010);
      chk("q3_bits", io_out_3_bits, 8'hC3);
      chk("q1_head", io_out_1_bits, 8'h11);

      // No pass-through: dequeue from full queue 1 while offering to it.
      io_out_1_ready = 1'b1;
      io_out_3_ready = 1'b1;
      offer(1'b1, 2'd1, 8'h33);
      chk("nopass_ready", io_in_ready, 1'b0);
      chk("nopass_fire", io_fire, 1'b0);
      step();
      io_out_1_ready = 1'b0;
      io_out_3_ready = 1'b0;
      #1;
      chk("nopass_head", io_out_1_bits, 8'h22);
      chk("nopass_q3_empty", io_out_3_valid, 1'b0);
      chk("retry_ready", io_in_ready, 1'b1);
      step();
      offer(1'b0, 2'd0, 8'h00);
      io_out_1_ready = 1'b1;
      chk("q1_still_22", io_out_1_bits, 8'h22);
      step();
      chk("q1_then_33", io_out_1_bits, 8'h33);
      chk("q1_valid_33", io_out_1_valid, 1'b1);
      step();
      io_out_1_ready = 1'b0;
      #1;
      chk_valids("all_empty", 4'b0000);

      // Ordered streaming through queue 0, wrapping pointers several times.
      io_out_0_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         offer(1'b1, 2'd0, 8'(i));
         chk($sformatf("stream_ready_%0d", i), io_in_ready, 1'b1);
         if (i > 1) begin
            chk($sformatf("stream_valid_%0d", i), io_out_0_valid, 1'b1);
            chk($sformatf("stream_bits_%0d", i), io_out_0_bits, 32'(i - 1));
         end
         step();
      end
      offer(1'b0, 2'd0, 8'h00);
      chk("stream_last_valid", io_out_0_valid, 1'b1);
      chk("stream_last_bits", io_out_0_bits, 8'h08);
      step();
      io_out_0_ready = 1'b0;
      #1;
      chk("stream_empty", io_out_0_valid, 1'b0);

      // Mid-operation reset discards queued beats.
      offer(1'b1, 2'd0, 8'hA0);
      step();
      offer(1'b1, 2'd0, 8'hA1);
      step();
      offer(1'b1, 2'd3, 8'hB0);
      step();
      offer(1'b1, 2'd3, 8'hB1);
      step();
      offer(1'b0, 2'd0, 8'h00);
      chk_valids("prefill_valids", 4'b1001);
      reset          = 1'b0;
      io_out_0_ready = 1'b1;
      offer(1'b1, 2'd2, 8'hEE);
      chk("midrst_ready", io_in_ready, 1'b0);
      chk("midrst_fire", io_fire, 1'b0);
      chk("midrst_out0_valid", io_out_0_valid, 1'b0);
      step();
      reset          = 1'b1;
      io_out_0_ready = 1'b0;
      offer(1'b0, 2'd0, 8'h00);
      chk_valids("after_midrst_valids", 4'b0000);
      offer(1'b1, 2'd3, 8'h7E);
      chk("post_midrst_fire", io_fire, 1'b1);
      step();
      offer(1'b0, 2'd0, 8'h00);
      chk_valids("post_midrst_valids", 4'b1000);
      chk("post_midrst_bits", io_out_3_bits, 8'h7E);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
